// File: rtl/wb_bus_pkg.sv
// Shared Wishbone bus constants, arbiter state encoding and sizing helpers.
// Pure declarations; no logic, latency or backpressure of its own.
package wb_bus_pkg;

  localparam int WB_DEF_NUM_MASTERS = 4;
  localparam int WB_DEF_DATA_MSB    = 15;
  localparam int WB_DEF_ADDR_MSB    = 15;
  localparam int WB_DEF_TIMEOUT     = 1023;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A disabled watchdog still needs a legal 1-bit counter.
  function automatic int wdog_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first requester after i_last, wrapping; combinational, zero latency.
// No backpressure; o_any=0 when no request is present.
module rr_priority_select
  import wb_bus_pkg::*;
#(
  parameter int NUM_MASTERS = WB_DEF_NUM_MASTERS,
  parameter int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_last,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [IW-1:0]          o_idx,
  output logic                   o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    // k=NUM_MASTERS revisits i_last itself, so it ends up lowest priority.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = IW'((int'(i_last) + k) % NUM_MASTERS);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// N-master to 1-slave Wishbone arbiter, round-robin, no preemption, grant 2 cycles after request.
// Non-granted masters see STALL=1; slave STALL/ACK pass through to the granted master only.
module wb_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int NUM_MASTERS           = WB_DEF_NUM_MASTERS,
  parameter int WISHBONE_DATAWIDTH    = WB_DEF_DATA_MSB,
  parameter int WISHBONE_ADDRESSWIDTH = WB_DEF_ADDR_MSB,
  parameter int TIMEOUT_CYCLES        = WB_DEF_TIMEOUT
) (
  input  logic                                              CLK_I,
  input  logic                                              RST_I,
  input  logic [NUM_MASTERS-1:0]                            M_CYC_I,
  input  logic [NUM_MASTERS-1:0]                            M_STB_I,
  input  logic [NUM_MASTERS-1:0]                            M_WE_I,
  input  logic [NUM_MASTERS*(WISHBONE_ADDRESSWIDTH+1)-1:0]  M_ADR_I,
  input  logic [NUM_MASTERS*(WISHBONE_DATAWIDTH+1)-1:0]     M_DAT_I,
  output logic [WISHBONE_DATAWIDTH:0]                       M_DAT_O,
  output logic [NUM_MASTERS-1:0]                            M_ACK_O,
  output logic [NUM_MASTERS-1:0]                            M_STALL_O,
  output logic [NUM_MASTERS-1:0]                            M_GNT_O,
  output logic                                              S_CYC_O,
  output logic                                              S_STB_O,
  output logic                                              S_WE_O,
  output logic [WISHBONE_ADDRESSWIDTH:0]                    S_ADR_O,
  output logic [WISHBONE_DATAWIDTH:0]                       S_DAT_O,
  input  logic [WISHBONE_DATAWIDTH:0]                       S_DAT_I,
  input  logic                                              S_ACK_I,
  input  logic                                              S_STALL_I,
  output logic                                              TIMEOUT_O
);

  localparam int DW  = WISHBONE_DATAWIDTH + 1;
  localparam int AW  = WISHBONE_ADDRESSWIDTH + 1;
  localparam int IW  = idx_width(NUM_MASTERS);
  localparam int WDW = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);
  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]          r_last, w_last_nxt;
  logic [WDW-1:0]         r_wdog, w_wdog_nxt;

  logic [NUM_MASTERS-1:0] w_sel_gnt;
  logic [IW-1:0]          w_sel_idx;
  logic                   w_sel_any;
  logic                   w_timeout;
  logic                   w_busy;

  rr_priority_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_rr (
    .i_req  (M_CYC_I),
    .i_last (r_last),
    .o_gnt  (w_sel_gnt),
    .o_idx  (w_sel_idx),
    .o_any  (w_sel_any)
  );

  assign w_timeout = WD_EN && (r_state == ST_BUSY) && (r_wdog == WD_LIMIT);
  assign w_busy    = (r_state == ST_BUSY) && !w_timeout;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      ST_IDLE: begin
        if (|M_CYC_I) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (w_sel_any) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_sel_gnt;
          w_last_nxt  = w_sel_idx;
          w_wdog_nxt  = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        w_wdog_nxt = r_wdog + 1'b1;
        if (w_timeout || !M_CYC_I[r_last]) begin
          w_state_nxt = ST_RELEASE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // r_last doubles as the current grant index while BUSY.
  assign S_CYC_O   = w_busy & M_CYC_I[r_last];
  assign S_STB_O   = w_busy & M_STB_I[r_last];
  assign S_WE_O    = w_busy & M_WE_I[r_last];
  assign S_ADR_O   = M_ADR_I[r_last*AW +: AW];
  assign S_DAT_O   = M_DAT_I[r_last*DW +: DW];
  assign M_DAT_O   = S_DAT_I;
  assign M_GNT_O   = w_timeout ? '0 : r_gnt;
  assign TIMEOUT_O = w_timeout;

  always_comb begin
    M_ACK_O   = '0;
    M_STALL_O = '1;
    if (w_busy) begin
      M_ACK_O[r_last]   = S_ACK_I;
      M_STALL_O[r_last] = S_STALL_I;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: stimulus schedules expectations by cycle,
// a negedge monitor pops them against grant/ACK/timeout events and signal probes.
module tb_wb_bus_arbiter;

  localparam int N = 4;

  localparam int P_GNT   = 0;
  localparam int P_SCYC  = 1;
  localparam int P_SSTB  = 2;
  localparam int P_SWE   = 3;
  localparam int P_STALL = 4;
  localparam int P_ACK   = 5;
  localparam int P_TO    = 6;
  localparam int P_SADR  = 7;
  localparam int P_SDAT  = 8;
  localparam int P_MDAT  = 9;

  typedef struct {
    logic [N-1:0] val;
    int           cyc;
  } ev_t;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       nm;
  } probe_t;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic [N-1:0]    M_CYC_I, M_STB_I, M_WE_I;
  logic [N*16-1:0] M_ADR_I, M_DAT_I;
  logic [15:0]     M_DAT_O;
  logic [N-1:0]    M_ACK_O, M_STALL_O, M_GNT_O;
  logic            S_CYC_O, S_STB_O, S_WE_O;
  logic [15:0]     S_ADR_O, S_DAT_O, S_DAT_I;
  logic            S_ACK_I, S_STALL_I;
  logic            TIMEOUT_O;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;
  ev_t    q_gnt[$];
  ev_t    q_ack[$];
  ev_t    q_to[$];
  probe_t q_probe[$];

  wb_bus_arbiter #(
    .NUM_MASTERS           (N),
    .WISHBONE_DATAWIDTH    (15),
    .WISHBONE_ADDRESSWIDTH (15),
    .TIMEOUT_CYCLES        (8)
  ) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .M_CYC_I   (M_CYC_I),
    .M_STB_I   (M_STB_I),
    .M_WE_I    (M_WE_I),
    .M_ADR_I   (M_ADR_I),
    .M_DAT_I   (M_DAT_I),
    .M_DAT_O   (M_DAT_O),
    .M_ACK_O   (M_ACK_O),
    .M_STALL_O (M_STALL_O),
    .M_GNT_O   (M_GNT_O),
    .S_CYC_O   (S_CYC_O),
    .S_STB_O   (S_STB_O),
    .S_WE_O    (S_WE_O),
    .S_ADR_O   (S_ADR_O),
    .S_DAT_O   (S_DAT_O),
    .S_DAT_I   (S_DAT_I),
    .S_ACK_I   (S_ACK_I),
    .S_STALL_I (S_STALL_I),
    .TIMEOUT_O (TIMEOUT_O)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic probe(input int c, input int sig, input logic [15:0] v, input string nm);
    probe_t p;
    p.cyc = c; p.sig = sig; p.val = v; p.nm = nm;
    q_probe.push_back(p);
  endtask

  task automatic exp_gnt(input logic [N-1:0] v, input int c);
    ev_t e; e.val = v; e.cyc = c; q_gnt.push_back(e);
  endtask

  task automatic exp_ack(input logic [N-1:0] v, input int c);
    ev_t e; e.val = v; e.cyc = c; q_ack.push_back(e);
  endtask

  task automatic exp_to(input int c);
    ev_t e; e.val = '0; e.cyc = c; q_to.push_back(e);
  endtask

  // Stimulus: all expected values/cycles hand-derived from the 4-state FSM timing.
  initial begin
    RST_I = 1'b0; M_CYC_I = '0; M_STB_I = '0; M_WE_I = '0;
    M_ADR_I = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    M_DAT_I = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    S_DAT_I = '0; S_ACK_I = 1'b0; S_STALL_I = 1'b0;

    goto(1);
    probe(1, P_GNT, 16'h0, "rst_gnt");   probe(1, P_SCYC, 16'h0, "rst_scyc");
    probe(1, P_SSTB, 16'h0, "rst_sstb"); probe(1, P_TO, 16'h0, "rst_to");
    probe(1, P_STALL, 16'hF, "rst_stall"); probe(1, P_ACK, 16'h0, "rst_ack");
    goto(2); RST_I = 1'b1;

    // Two requesters after reset: master 0 first, master 2 after turnaround.
    goto(4); M_CYC_I = 4'b0101; M_STB_I = 4'b0101;
    exp_gnt(4'b0001, 6); exp_gnt(4'b0100, 12);
    probe(6, P_SCYC, 16'h1, "t1_scyc"); probe(6, P_SSTB, 16'h1, "t1_sstb");
    probe(6, P_SADR, 16'hA000, "t1_sadr"); probe(6, P_SWE, 16'h0, "t1_swe");
    goto(8); M_CYC_I = 4'b0100; M_STB_I = 4'b0100;
    probe(9, P_GNT, 16'h0, "t1_rel_gnt"); probe(9, P_SCYC, 16'h0, "t1_rel_scyc");
    probe(12, P_SADR, 16'hA002, "t1_sadr2");
    goto(13); M_CYC_I = '0; M_STB_I = '0;
    goto(16); RST_I = 1'b0;
    goto(18); RST_I = 1'b1;

    // Four continuous requesters, 3-cycle tenures: 0,1,2,3,0 every 6 cycles.
    goto(20); M_CYC_I = 4'b1111; M_STB_I = 4'b1111;
    for (int i = 0; i < 5; i++) exp_gnt(4'(1 << (i % 4)), 22 + 6 * i);
    for (int i = 0; i < 5; i++) begin
      goto(22 + 6 * i + 2);
      if (i == 4) M_CYC_I = '0;
      else        M_CYC_I[i % 4] = 1'b0;
      goto(22 + 6 * i + 3);
      probe(22 + 6 * i + 3, P_GNT, 16'h0, "t2_gap");
      if (i < 4) M_CYC_I[i % 4] = 1'b1;
    end
    M_STB_I = '0;

    // Master 1 with slave stall, then ACK routing and ACK discard in RELEASE.
    goto(52); M_CYC_I = 4'b0010; M_STB_I = 4'b0010; M_WE_I = 4'b0010; S_STALL_I = 1'b1;
    exp_gnt(4'b0010, 54);
    probe(54, P_SCYC, 16'h1, "t3_scyc"); probe(54, P_SWE, 16'h1, "t3_swe");
    probe(54, P_SADR, 16'hA001, "t3_sadr"); probe(54, P_SDAT, 16'hD001, "t3_sdat");
    for (int c = 54; c < 59; c++) begin
      probe(c, P_STALL, 16'hF, "t3_stall"); probe(c, P_ACK, 16'h0, "t3_noack");
    end
    goto(59); S_STALL_I = 1'b0; S_DAT_I = 16'hBEEF;
    probe(59, P_STALL, 16'hD, "t3_unstall"); probe(59, P_MDAT, 16'hBEEF, "t3_mdat");
    goto(60); S_ACK_I = 1'b1; exp_ack(4'b0010, 60);
    goto(61); S_ACK_I = 1'b0; M_CYC_I = '0; M_STB_I = '0; M_WE_I = '0;
    goto(62); S_ACK_I = 1'b1;
    probe(62, P_ACK, 16'h0, "t3_rel_ack"); probe(62, P_GNT, 16'h0, "t3_rel_gnt");
    goto(63); S_ACK_I = 1'b0;

    // Watchdog: master 2 hogs; timeout at BUSY count 8, master 3 next, then 2 again.
    goto(66); M_CYC_I = 4'b1100; M_STB_I = 4'b1100;
    exp_gnt(4'b0100, 68); exp_to(76); exp_gnt(4'b1000, 80); exp_gnt(4'b0100, 86);
    probe(75, P_GNT, 16'h4, "t4_pre_gnt"); probe(75, P_TO, 16'h0, "t4_pre_to");
    probe(76, P_GNT, 16'h0, "t4_to_gnt");  probe(76, P_SCYC, 16'h0, "t4_to_scyc");
    probe(77, P_TO, 16'h0, "t4_to_once");
    goto(82); M_CYC_I[3] = 1'b0; M_STB_I[3] = 1'b0;
    goto(86); M_CYC_I = '0; M_STB_I = '0;

    // One-cycle request pulse withdrawn before ARB completes.
    goto(90); M_CYC_I = 4'b0001; M_STB_I = 4'b0001;
    goto(91); M_CYC_I = '0; M_STB_I = '0;
    probe(91, P_SSTB, 16'h0, "t6_sstb");
    for (int c = 92; c < 95; c++) begin
      probe(c, P_GNT, 16'h0, "t6_gnt"); probe(c, P_SCYC, 16'h0, "t6_scyc");
    end

    // Async reset mid-BUSY with ACK arriving, then master 0 wins again.
    goto(96); M_CYC_I = 4'b0010; M_STB_I = 4'b0010;
    exp_gnt(4'b0010, 98);
    probe(99, P_SCYC, 16'h1, "t5_pre_scyc");
    goto(100); RST_I = 1'b0; S_ACK_I = 1'b1;
    probe(100, P_GNT, 16'h0, "t5_rst_gnt"); probe(100, P_SCYC, 16'h0, "t5_rst_scyc");
    probe(100, P_ACK, 16'h0, "t5_rst_ack");
    goto(102); S_ACK_I = 1'b0; M_CYC_I = 4'b0011; M_STB_I = 4'b0011;
    goto(103); RST_I = 1'b1;
    exp_gnt(4'b0001, 105);
    goto(107); M_CYC_I = '0; M_STB_I = '0;
    goto(110); done = 1'b1;
  end

  function automatic logic [15:0] sample(input int sig);
    case (sig)
      P_GNT:   return 16'(M_GNT_O);
      P_SCYC:  return 16'(S_CYC_O);
      P_SSTB:  return 16'(S_STB_O);
      P_SWE:   return 16'(S_WE_O);
      P_STALL: return 16'(M_STALL_O);
      P_ACK:   return 16'(M_ACK_O);
      P_TO:    return 16'(TIMEOUT_O);
      P_SADR:  return S_ADR_O;
      P_SDAT:  return S_DAT_O;
      P_MDAT:  return M_DAT_O;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic ev_check(input string nm, input logic [N-1:0] act, input bit have, input ev_t e);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected at cyc %0d: got %b, none expected", nm, cyc, act);
    end else if (act !== e.val || cyc != e.cyc) begin
      errors++;
      $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d", nm, act, cyc, e.val, e.cyc);
    end
  endtask

  task automatic leftover(input string nm, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s never observed: %0d pending, want 0", nm, n);
    end
  endtask

  // Monitor: probes, then grant-rise / ACK / timeout events, all sampled on negedge.
  initial begin
    logic [N-1:0] prev_gnt;
    logic [15:0]  act;
    probe_t       p;
    ev_t          e;
    bit           have;
    prev_gnt = '0;
    forever begin
      @(negedge CLK_I);
      while (q_probe.size() != 0 && q_probe[0].cyc <= cyc) begin
        p = q_probe.pop_front();
        act = sample(p.sig);
        checks++;
        if (p.cyc != cyc || act !== p.val) begin
          errors++;
          $display("FAIL %s cyc %0d: got %h, want %h", p.nm, cyc, act, p.val);
        end
      end
      if (RST_I === 1'b1) begin
        if (M_GNT_O != '0 && prev_gnt == '0) begin
          have = (q_gnt.size() != 0);
          e.val = '0; e.cyc = -1;
          if (have) e = q_gnt.pop_front();
          ev_check("gnt", M_GNT_O, have, e);
        end
        if (M_ACK_O != '0) begin
          have = (q_ack.size() != 0);
          e.val = '0; e.cyc = -1;
          if (have) e = q_ack.pop_front();
          ev_check("ack", M_ACK_O, have, e);
        end
        if (TIMEOUT_O) begin
          have = (q_to.size() != 0);
          e.val = '0; e.cyc = -1;
          if (have) e = q_to.pop_front();
          ev_check("timeout", '0, have, e);
        end
      end
      prev_gnt = M_GNT_O;
      if (done) begin
        leftover("gnt", q_gnt.size());
        leftover("ack", q_ack.size());
        leftover("timeout", q_to.size());
        leftover("probe", q_probe.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
